fdtd_update_engine: RTL and testbench

FDTD_UPDATE_ENGINE -- requirements
Module: fdtd_update_engine

---
 rtl/fdtd_pkg.sv | 18 +
 rtl/fdtd_mac.sv | 67 ++++++
 rtl/fdtd_update_engine.sv | 204 ++++++++++++++++++++
 tb/tb_fdtd_update_engine.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fdtd_pkg.sv
// Shared types and constants for the FDTD field-update engine: FSM state
// encoding, field-mode encoding and the read-to-write pipeline latency.
package fdtd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fdtd_state_t;

    localparam logic MODE_HY = 1'b0;
    localparam logic MODE_EZ = 1'b1;

    // Cycles from a read enable to the write strobe of the result it completes.
    localparam int PIPE_LATENCY = 3;

endpackage

// File: rtl/fdtd_mac.sv
// Update arithmetic: base + ((coef * (plus - minus)) >>> COEF_FRAC_BITS), one output register.
// Macro FDTD_UPDATE_SAT_EN selects saturation of the final sum; otherwise the sum wraps.
module fdtd_mac
    import fdtd_pkg::*;
#(
    parameter int FDTD_DATA_WIDTH = 32,
    parameter int COEF_FRAC_BITS  = 16
) (
    input  logic                               CLK,
    input  logic                               RST,
    input  logic                               valid_i,
    input  logic signed [FDTD_DATA_WIDTH-1:0]  base_i,
    input  logic signed [FDTD_DATA_WIDTH-1:0]  plus_i,
    input  logic signed [FDTD_DATA_WIDTH-1:0]  minus_i,
    input  logic signed [FDTD_DATA_WIDTH-1:0]  coef_i,
    output logic                               valid_o,
    output logic signed [FDTD_DATA_WIDTH-1:0]  result_o
);

    localparam int D  = FDTD_DATA_WIDTH;
    localparam int PW = 2 * D + 1;

    logic signed [D:0]    diff;
    logic signed [PW-1:0] coef_x;
    logic signed [PW-1:0] diff_x;
    logic signed [PW-1:0] prod;
    logic signed [D-1:0]  result_d;
`ifdef FDTD_UPDATE_SAT_EN
    logic signed [PW-1:0] scaled;
    logic signed [PW:0]   sum;
    logic                 ovf;
`endif

    always_comb begin
        // The difference carries one extra bit so opposite-signed extremes never wrap.
        diff   = {plus_i[D-1], plus_i} - {minus_i[D-1], minus_i};
        coef_x = {{(D+1){coef_i[D-1]}}, coef_i};
        diff_x = {{D{diff[D]}}, diff};
        prod   = coef_x * diff_x;
`ifdef FDTD_UPDATE_SAT_EN
        scaled = prod >>> COEF_FRAC_BITS;
        sum    = {scaled[PW-1], scaled} + {{(PW+1-D){base_i[D-1]}}, base_i};
        // Out of range whenever the bits above the result sign disagree with it.
        ovf    = ~(&sum[PW:D-1]) & (|sum[PW:D-1]);
        if (ovf) begin
            result_d = sum[PW] ? {1'b1, {(D-1){1'b0}}} : {1'b0, {(D-1){1'b1}}};
        end else begin
            result_d = sum[D-1:0];
        end
`else
        result_d = D'(prod >>> COEF_FRAC_BITS) + base_i;
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_o  <= 1'b0;
            result_o <= '0;
        end else begin
            valid_o <= valid_i;
            if (valid_i) begin
                result_o <= result_d;
            end
        end
    end

endmodule

// File: rtl/fdtd_update_engine.sv
// Streams one line of old fields through the FDTD update and writes the new line.
// Build with macro FDTD_UPDATE_SAT_EN to saturate results instead of wrapping.
module fdtd_update_engine
    import fdtd_pkg::*;
#(
    parameter int FDTD_DATA_WIDTH   = 32,
    parameter int BUFFER_ADDR_WIDTH = 6,
    parameter int COEF_FRAC_BITS    = 16
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          start_i,
    input  logic                          mode_i,
    input  logic [BUFFER_ADDR_WIDTH:0]    len_i,
    input  logic [FDTD_DATA_WIDTH-1:0]    coef_i,
    output logic                          rd_Hy_old_en_o,
    output logic                          rd_Ez_old_en_o,
    output logic [BUFFER_ADDR_WIDTH-1:0]  rd_Hy_old_addr_o,
    output logic [BUFFER_ADDR_WIDTH-1:0]  rd_Ez_old_addr_o,
    input  logic [FDTD_DATA_WIDTH-1:0]    Hy_old_i,
    input  logic [FDTD_DATA_WIDTH-1:0]    Ez_old_i,
    output logic                          wrt_Hy_n_en_o,
    output logic                          wrt_Ez_n_en_o,
    output logic [BUFFER_ADDR_WIDTH-1:0]  wrt_Hy_n_addr_o,
    output logic [BUFFER_ADDR_WIDTH-1:0]  wrt_Ez_n_addr_o,
    output logic [FDTD_DATA_WIDTH-1:0]    Hy_n_o,
    output logic [FDTD_DATA_WIDTH-1:0]    Ez_n_o,
    output logic                          busy_o,
    output logic                          done_o,
    output logic [1:0]                    dbg_state_o
);

    localparam int D = FDTD_DATA_WIDTH;
    localparam int A = BUFFER_ADDR_WIDTH;
    localparam logic [A:0] LEN_ONE = 1;

    // Handshake: start_i is a one-cycle request accepted only in IDLE; read data
    // is valid on Hy_old_i/Ez_old_i the cycle after its enable; each write strobe
    // is a single-cycle, unacknowledged store of data/address on the same cycle.

    fdtd_state_t          state;
    logic                 mode_q;
    logic [A:0]           len_q;
    logic signed [D-1:0]  coef_q;
    logic                 rd_en_q;
    logic [A-1:0]         rd_addr_q;
    logic                 done_q;
    logic                 phantom_q;

    logic                 s1_valid;
    logic                 s1_phantom;
    logic                 s1_first;
    logic signed [D-1:0]  hy_cur;
    logic signed [D-1:0]  ez_cur;
    logic signed [D-1:0]  hy_prev;
    logic signed [D-1:0]  ez_prev;

    logic                 s2_valid;
    logic signed [D-1:0]  s2_base;
    logic signed [D-1:0]  s2_plus;
    logic signed [D-1:0]  s2_minus;

    logic                 mac_valid;
    logic signed [D-1:0]  mac_result;
    logic [A:0]           wr_cnt;
    logic                 last_wr;

    assign last_wr = mac_valid && (wr_cnt == len_q - LEN_ONE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            mode_q    <= MODE_HY;
            len_q     <= '0;
            coef_q    <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            done_q    <= 1'b0;
            phantom_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            phantom_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        mode_q    <= mode_i;
                        len_q     <= len_i;
                        coef_q    <= coef_i;
                        rd_addr_q <= '0;
                        if (len_i == '0) begin
                            state  <= ST_DONE;
                            done_q <= 1'b1;
                        end else begin
                            state   <= ST_READ;
                            rd_en_q <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    if ({1'b0, rd_addr_q} == len_q - LEN_ONE) begin
                        state     <= ST_DRAIN;
                        rd_en_q   <= 1'b0;
                        rd_addr_q <= '0;
                        // Hy results lag one read; a zero "read len" flushes the last one.
                        phantom_q <= (mode_q == MODE_HY);
                    end else begin
                        rd_addr_q <= rd_addr_q + A'(1);
                    end
                end
                ST_DRAIN: begin
                    if (last_wr) begin
                        state  <= ST_DONE;
                        done_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        hy_cur = s1_phantom ? '0 : Hy_old_i;
        ez_cur = s1_phantom ? '0 : Ez_old_i;
    end

    // Stage 1 sees read data; stage 2 holds the operands presented to the MAC.
    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_valid   <= 1'b0;
            s1_phantom <= 1'b0;
            s1_first   <= 1'b0;
            hy_prev    <= '0;
            ez_prev    <= '0;
            s2_valid   <= 1'b0;
            s2_base    <= '0;
            s2_plus    <= '0;
            s2_minus   <= '0;
        end else begin
            s1_valid   <= rd_en_q | phantom_q;
            s1_phantom <= phantom_q;
            s1_first   <= rd_en_q && (rd_addr_q == '0);
            if (s1_valid) begin
                hy_prev <= hy_cur;
                ez_prev <= ez_cur;
            end
            if (mode_q == MODE_EZ) begin
                s2_valid <= s1_valid & ~s1_phantom;
                s2_base  <= ez_cur;
                s2_plus  <= hy_cur;
                s2_minus <= s1_first ? '0 : hy_prev;
            end else begin
                s2_valid <= s1_valid & ~s1_first;
                s2_base  <= hy_prev;
                s2_plus  <= ez_cur;
                s2_minus <= ez_prev;
            end
        end
    end

    fdtd_mac #(
        .FDTD_DATA_WIDTH (D),
        .COEF_FRAC_BITS  (COEF_FRAC_BITS)
    ) u_mac (
        .CLK      (CLK),
        .RST      (RST),
        .valid_i  (s2_valid),
        .base_i   (s2_base),
        .plus_i   (s2_plus),
        .minus_i  (s2_minus),
        .coef_i   (coef_q),
        .valid_o  (mac_valid),
        .result_o (mac_result)
    );

    always_ff @(posedge CLK) begin
        if (RST || state == ST_IDLE) begin
            wr_cnt <= '0;
        end else if (mac_valid) begin
            wr_cnt <= wr_cnt + LEN_ONE;
        end
    end

    assign rd_Hy_old_en_o   = rd_en_q;
    assign rd_Ez_old_en_o   = rd_en_q;
    assign rd_Hy_old_addr_o = rd_addr_q;
    assign rd_Ez_old_addr_o = rd_addr_q;

    assign wrt_Hy_n_en_o    = mac_valid && (mode_q == MODE_HY);
    assign wrt_Ez_n_en_o    = mac_valid && (mode_q == MODE_EZ);
    assign wrt_Hy_n_addr_o  = wr_cnt[A-1:0];
    assign wrt_Ez_n_addr_o  = wr_cnt[A-1:0];
    assign Hy_n_o           = (mode_q == MODE_HY) ? mac_result : '0;
    assign Ez_n_o           = (mode_q == MODE_EZ) ? mac_result : '0;

    assign busy_o      = (state != ST_IDLE);
    assign done_o      = done_q;
    assign dbg_state_o = state;

endmodule

// File: tb/tb_fdtd_update_engine.sv
// Directed bench for fdtd_update_engine: RAM model, event monitor, hand-computed results.
// Expected saturation result follows macro FDTD_UPDATE_SAT_EN.
module tb_fdtd_update_engine;

    localparam logic M_HY = 1'b0;
    localparam logic M_EZ = 1'b1;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start_i;
    logic        mode_i;
    logic [6:0]  len_i;
    logic [31:0] coef_i;
    logic        rd_Hy_old_en_o, rd_Ez_old_en_o;
    logic [5:0]  rd_Hy_old_addr_o, rd_Ez_old_addr_o;
    logic [31:0] hy_rd = '0;
    logic [31:0] ez_rd = '0;
    logic        wrt_Hy_n_en_o, wrt_Ez_n_en_o;
    logic [5:0]  wrt_Hy_n_addr_o, wrt_Ez_n_addr_o;
    logic [31:0] Hy_n_o, Ez_n_o;
    logic        busy_o, done_o;
    logic [1:0]  dbg_state_o;

    logic [31:0] hy_mem [64];
    logic [31:0] ez_mem [64];
    logic [31:0] exp_q [$];

    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    int          rd_cyc_q [$];
    int          rd_adr_q [$];
    int          wr_cyc_q [$];
    int          wr_adr_q [$];
    logic [31:0] wr_dat_q [$];
    int          done_cyc_q [$];
    int          n_hy_wr = 0;
    int          n_ez_wr = 0;
    int          rd_skew = 0;

    fdtd_update_engine dut (
        .CLK              (CLK),
        .RST              (RST),
        .start_i          (start_i),
        .mode_i           (mode_i),
        .len_i            (len_i),
        .coef_i           (coef_i),
        .rd_Hy_old_en_o   (rd_Hy_old_en_o),
        .rd_Ez_old_en_o   (rd_Ez_old_en_o),
        .rd_Hy_old_addr_o (rd_Hy_old_addr_o),
        .rd_Ez_old_addr_o (rd_Ez_old_addr_o),
        .Hy_old_i         (hy_rd),
        .Ez_old_i         (ez_rd),
        .wrt_Hy_n_en_o    (wrt_Hy_n_en_o),
        .wrt_Ez_n_en_o    (wrt_Ez_n_en_o),
        .wrt_Hy_n_addr_o  (wrt_Hy_n_addr_o),
        .wrt_Ez_n_addr_o  (wrt_Ez_n_addr_o),
        .Hy_n_o           (Hy_n_o),
        .Ez_n_o           (Ez_n_o),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .dbg_state_o      (dbg_state_o)
    );

    // Clock, cycle counter and synchronous-read RAM model (garbage when not enabled).
    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        cyc   <= cyc + 1;
        hy_rd <= rd_Hy_old_en_o ? hy_mem[rd_Hy_old_addr_o] : 32'hDEADBEEF;
        ez_rd <= rd_Ez_old_en_o ? ez_mem[rd_Ez_old_addr_o] : 32'hBADC0FFE;
    end

    always @(negedge CLK) begin
        if (rd_Hy_old_en_o != rd_Ez_old_en_o ||
            (rd_Hy_old_en_o && rd_Hy_old_addr_o != rd_Ez_old_addr_o))
            rd_skew++;
        if (rd_Hy_old_en_o) begin
            rd_cyc_q.push_back(cyc);
            rd_adr_q.push_back(int'(rd_Hy_old_addr_o));
        end
        if (wrt_Ez_n_en_o) n_ez_wr++;
        if (wrt_Hy_n_en_o) n_hy_wr++;
        if (wrt_Ez_n_en_o || wrt_Hy_n_en_o) begin
            wr_cyc_q.push_back(cyc);
            wr_adr_q.push_back(int'(wrt_Ez_n_en_o ? wrt_Ez_n_addr_o : wrt_Hy_n_addr_o));
            wr_dat_q.push_back(wrt_Ez_n_en_o ? Ez_n_o : Hy_n_o);
        end
        if (done_o) done_cyc_q.push_back(cyc);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        rd_cyc_q = {};
        rd_adr_q = {};
        wr_cyc_q = {};
        wr_adr_q = {};
        wr_dat_q = {};
        done_cyc_q = {};
        n_hy_wr = 0;
        n_ez_wr = 0;
        rd_skew = 0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) begin
            hy_mem[i] = '0;
            ez_mem[i] = '0;
        end
        exp_q = {};
    endtask

    task automatic run_op(input logic mode, input int len, input logic [31:0] coef, output int ns);
        clear_mon();
        @(posedge CLK); #1;
        start_i = 1'b1;
        mode_i  = mode;
        len_i   = len[6:0];
        coef_i  = coef;
        ns      = cyc;
        @(posedge CLK); #1;
        start_i = 1'b0;
        mode_i  = 1'(($urandom_range(0, 1)));
        len_i   = 7'($urandom_range(0, 64));
        coef_i  = $urandom;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done_cyc_q.size() == 0 && n < 300) begin
            @(posedge CLK); #1;
            n++;
        end
        check_eq({tag, " done_seen"}, 64'(done_cyc_q.size() != 0), 64'd1);
        repeat (4) @(posedge CLK);
        #1;
        check_eq({tag, " busy_after"}, 64'(busy_o), 64'd0);
    endtask

    task automatic verify_run(input string tag, input logic mode, input int len, input int ns);
        int first_wr;
        first_wr = (mode == M_EZ) ? ns + 4 : ns + 5;
        check_eq({tag, " n_rd"}, rd_cyc_q.size(), len);
        for (int k = 0; k < rd_cyc_q.size() && k < len; k++) begin
            check_eq($sformatf("%s rd_cyc[%0d]", tag, k), rd_cyc_q[k], ns + 1 + k);
            check_eq($sformatf("%s rd_addr[%0d]", tag, k), rd_adr_q[k], k);
        end
        check_eq({tag, " n_wr"}, wr_cyc_q.size(), len);
        for (int k = 0; k < wr_cyc_q.size() && k < len; k++) begin
            check_eq($sformatf("%s wr_cyc[%0d]", tag, k), wr_cyc_q[k], first_wr + k);
            check_eq($sformatf("%s wr_addr[%0d]", tag, k), wr_adr_q[k], k);
            check_eq($sformatf("%s wr_data[%0d]", tag, k), wr_dat_q[k], exp_q[k]);
        end
        check_eq({tag, " wrong_strobe"}, (mode == M_EZ) ? n_hy_wr : n_ez_wr, 0);
        check_eq({tag, " rd_skew"}, rd_skew, 0);
        check_eq({tag, " n_done"}, done_cyc_q.size(), 1);
        if (done_cyc_q.size() > 0)
            check_eq({tag, " done_cyc"}, done_cyc_q[0], (len == 0) ? ns + 1 : first_wr + len);
    endtask

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        int ns;
        int n_late;
        RST = 1'b1;
        start_i = 1'b0;
        mode_i = 1'b0;
        len_i = '0;
        coef_i = '0;
        clear_mem();
        repeat (3) @(posedge CLK);
        #1;
        check_eq("rst busy", 64'(busy_o), 0);
        check_eq("rst done", 64'(done_o), 0);
        check_eq("rst rd_en", 64'({rd_Hy_old_en_o, rd_Ez_old_en_o}), 0);
        check_eq("rst wr_en", 64'({wrt_Hy_n_en_o, wrt_Ez_n_en_o}), 0);
        check_eq("rst rd_addr", 64'({rd_Hy_old_addr_o, rd_Ez_old_addr_o}), 0);
        check_eq("rst wr_addr", 64'({wrt_Hy_n_addr_o, wrt_Ez_n_addr_o}), 0);
        check_eq("rst data", 64'({Hy_n_o, Ez_n_o}), 0);
        check_eq("rst state", 64'(dbg_state_o), 0);
        RST = 1'b0;

        // Ez, len 4, coef 1.0, Hy={1,2,3,4}: every cell sees a unit curl.
        clear_mem();
        for (int i = 0; i < 4; i++) hy_mem[i] = 32'(i + 1);
        for (int i = 0; i < 4; i++) exp_q.push_back(32'd1);
        run_op(M_EZ, 4, 32'h0001_0000, ns);
        check_eq("ez4 busy", 64'(busy_o), 1);
        wait_done("ez4");
        verify_run("ez4", M_EZ, 4, ns);

        // Hy, len 3, coef 0.5, Ez={2,6,10}: last cell uses Ez[len]=0.
        clear_mem();
        ez_mem[0] = 32'd2; ez_mem[1] = 32'd6; ez_mem[2] = 32'd10;
        exp_q.push_back(32'd2); exp_q.push_back(32'd2); exp_q.push_back(32'hFFFF_FFFB);
        run_op(M_HY, 3, 32'h0000_8000, ns);
        wait_done("hy3");
        verify_run("hy3", M_HY, 3, ns);

        // len 0: straight to DONE, no memory traffic.
        clear_mem();
        run_op(M_EZ, 0, 32'h0001_0000, ns);
        check_eq("len0 busy", 64'(busy_o), 1);
        wait_done("len0");
        verify_run("len0", M_EZ, 0, ns);

        // Overflow of the final sum.
        clear_mem();
        ez_mem[0] = 32'h7FFF_FFF0; hy_mem[0] = 32'h0000_0100;
`ifdef FDTD_UPDATE_SAT_EN
        exp_q.push_back(32'h7FFF_FFFF);
`else
        exp_q.push_back(32'h8000_00F0);
`endif
        run_op(M_EZ, 1, 32'h0001_0000, ns);
        wait_done("ovf");
        verify_run("ovf", M_EZ, 1, ns);

        // Ez, negative coef -0.5 with mixed-sign fields: {95,-47,12}.
        clear_mem();
        hy_mem[0] = 32'd10; hy_mem[1] = 32'd4; hy_mem[2] = 32'hFFFF_FFFA;
        ez_mem[0] = 32'd100; ez_mem[1] = 32'hFFFF_FFCE; ez_mem[2] = 32'd7;
        exp_q.push_back(32'd95); exp_q.push_back(32'hFFFF_FFD1); exp_q.push_back(32'd12);
        run_op(M_EZ, 3, 32'hFFFF_8000, ns);
        wait_done("ezneg");
        verify_run("ezneg", M_EZ, 3, ns);

        // Hy, coef 0.5, odd negative curl floors: 1+floor(-1.5)=-1, 1-1=0.
        clear_mem();
        ez_mem[0] = 32'd5; ez_mem[1] = 32'd2; hy_mem[0] = 32'd1; hy_mem[1] = 32'd1;
        exp_q.push_back(32'hFFFF_FFFF); exp_q.push_back(32'd0);
        run_op(M_HY, 2, 32'h0000_8000, ns);
        wait_done("hyflr");
        verify_run("hyflr", M_HY, 2, ns);

        // Difference needs 33 bits: 0x7FFFFFFF - 0x80000000 = 2^32-1.
        clear_mem();
        ez_mem[0] = 32'h8000_0000; ez_mem[1] = 32'h7FFF_FFFF;
        exp_q.push_back(32'h0000_FFFF); exp_q.push_back(32'hFFFF_8000);
        run_op(M_HY, 2, 32'h0000_0001, ns);
        wait_done("wide");
        verify_run("wide", M_HY, 2, ns);

        // Full buffer, len 64, Hy[k]=k: Ez_n = {0,1,1,...}.
        clear_mem();
        for (int i = 0; i < 64; i++) hy_mem[i] = 32'(i);
        exp_q.push_back(32'd0);
        for (int i = 1; i < 64; i++) exp_q.push_back(32'd1);
        run_op(M_EZ, 64, 32'h0001_0000, ns);
        wait_done("full");
        verify_run("full", M_EZ, 64, ns);

        // Second start mid-READ is ignored; reset mid-DRAIN aborts everything.
        clear_mem();
        for (int i = 0; i < 8; i++) hy_mem[i] = 32'(i + 1);
        run_op(M_EZ, 8, 32'h0001_0000, ns);
        repeat (2) @(posedge CLK);
        #1;
        start_i = 1'b1; mode_i = M_HY; len_i = 7'd2; coef_i = 32'h0;
        @(posedge CLK); #1;
        start_i = 1'b0;
        repeat (5) @(posedge CLK);
        #1;
        check_eq("abort in_drain", 64'(dbg_state_o), 64'd2);
        RST = 1'b1;
        @(posedge CLK); #1;
        check_eq("abort rst busy", 64'(busy_o), 0);
        check_eq("abort rst wr_en", 64'({wrt_Hy_n_en_o, wrt_Ez_n_en_o}), 0);
        @(posedge CLK); #1;
        RST = 1'b0;
        repeat (20) @(posedge CLK);
        #1;
        n_late = 0;
        foreach (wr_cyc_q[k]) if (wr_cyc_q[k] > ns + 9) n_late++;
        check_eq("abort n_rd", rd_cyc_q.size(), 8);
        check_eq("abort n_wr_before", wr_cyc_q.size(), 6);
        check_eq("abort late_wr", n_late, 0);
        check_eq("abort hy_strobe", n_hy_wr, 0);
        check_eq("abort n_done", done_cyc_q.size(), 0);
        for (int k = 0; k < wr_dat_q.size() && k < 6; k++)
            check_eq($sformatf("abort wr_data[%0d]", k), wr_dat_q[k], 32'd1);

        // Normal operation resumes after the abort.
        clear_mem();
        for (int i = 0; i < 4; i++) hy_mem[i] = 32'(i + 1);
        for (int i = 0; i < 4; i++) exp_q.push_back(32'd1);
        run_op(M_EZ, 4, 32'h0001_0000, ns);
        wait_done("resume");
        verify_run("resume", M_EZ, 4, ns);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
